id_decode_queue: RTL and testbench

- Parametrised decode stage for the RV32I pipeline: a DEPTH-entry instruction queue between the fetch response and the ID/EX boundary, a full RV32I control decoder, register-file read, and a registered, handshaked output toward EX.
- Unlike the single-register decode stage, it buffers fetch bursts, exerts backpressure in both directions, supports flush, and interlocks on load-use hazards.

---
 rtl/id_decode_queue.sv | 213 +++++++++++++++++++++
 tb/tb_id_decode_queue.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_queue.sv
// id_decode_queue
//   RV32I decode stage with a DEPTH-entry instruction queue in front of the
//   decoder and a registered output slot toward EX.
//
//   Fetch side : in_valid/in_ready/in_inst/in_pc/in_order
//   Regfile    : rs1_s/rs2_s (head of queue) -> rs1_v/rs2_v (combinational)
//   EX hazard  : ex_valid/ex_mem_re/ex_rd_s (load-use interlock)
//   EX side    : out_valid/out_ready plus decoded out_* fields
//   Control    : clk, rst (synchronous, active-low), flush
//
//   Handshakes: a transfer happens on a rising edge where valid & ready are
//   both high; valid never depends on ready of the same interface, and a
//   presented payload is held stable until it transfers.
//
//   Build option: define ID_LOAD_USE_STALL_EN to enable the load-use
//   interlock; without it the hazard term is 0 and ex_* are ignored.
module id_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int ORDER_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [ORDER_W-1:0] in_order,
  output logic [4:0]         rs1_s,
  output logic [4:0]         rs2_s,
  input  logic [31:0]        rs1_v,
  input  logic [31:0]        rs2_v,
  input  logic               ex_valid,
  input  logic               ex_mem_re,
  input  logic [4:0]         ex_rd_s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [PC_W-1:0]    out_pc,
  output logic [ORDER_W-1:0] out_order,
  output logic [4:0]         out_rd_s,
  output logic [31:0]        out_rs1_v,
  output logic [31:0]        out_rs2_v,
  output logic [31:0]        out_imm,
  output logic [2:0]         out_aluop,
  output logic               out_alu_m1_sel,
  output logic               out_alu_m2_sel,
  output logic [2:0]         out_cmpop,
  output logic               out_cmp_sel,
  output logic [3:0]         out_rd_m_sel,
  output logic               out_regf_we,
  output logic               out_mem_re,
  output logic               out_mem_we,
  output logic [2:0]         out_funct3,
  output logic               out_illegal
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  // ---------------- instruction queue ----------------
  logic [31:0]        q_inst  [DEPTH];
  logic [PC_W-1:0]    q_pc    [DEPTH];
  logic [ORDER_W-1:0] q_order [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, empty, push, issue, hazard;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  // Flush drops whatever fetch presents in the same cycle.
  assign push     = in_valid && in_ready && !flush;
  assign issue    = !empty && !hazard && (!out_valid || out_ready) && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr]  <= in_inst;
      q_pc[wr_ptr]    <= in_pc;
      q_order[wr_ptr] <= in_order;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- decode of the queue head ----------------
  logic [31:0] head;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign head   = q_inst[rd_ptr];
  assign opcode = head[6:0];
  assign funct3 = head[14:12];
  assign rs1_s  = head[19:15];
  assign rs2_s  = head[24:20];
  assign imm_i  = {{20{head[31]}}, head[31:20]};
  assign imm_s  = {{20{head[31]}}, head[31:25], head[11:7]};
  assign imm_b  = {{20{head[31]}}, head[7], head[30:25], head[11:8], 1'b0};
  assign imm_u  = {head[31:12], 12'b0};
  assign imm_j  = {{12{head[31]}}, head[19:12], head[20], head[30:21], 1'b0};

  logic [31:0] d_imm;
  logic [2:0]  d_aluop, d_cmpop;
  logic        d_m1, d_m2, d_cmp_sel, d_we, d_re, d_mwe, d_ill, is_imm;
  logic [3:0]  d_rd_m_sel;

  always_comb begin
    d_imm = '0; d_aluop = 3'b000; d_cmpop = 3'b000;
    d_m1 = 1'b0; d_m2 = 1'b0; d_cmp_sel = 1'b0;
    d_we = 1'b0; d_re = 1'b0; d_mwe = 1'b0; d_ill = 1'b0;
    d_rd_m_sel = 4'd0;
    is_imm = (opcode == OP_IMM);
    case (opcode)
      OP_LUI:   begin d_imm = imm_u; d_rd_m_sel = 4'd2; d_we = 1'b1; end
      OP_AUIPC: begin d_imm = imm_u; d_m1 = 1'b1; d_m2 = 1'b1; d_we = 1'b1; end
      // ALU computes the jump/branch target as pc+imm.
      OP_JAL:   begin d_imm = imm_j; d_m1 = 1'b1; d_m2 = 1'b1; d_rd_m_sel = 4'd3; d_we = 1'b1; end
      OP_JALR:  begin d_imm = imm_i; d_m2 = 1'b1; d_rd_m_sel = 4'd3; d_we = 1'b1; end
      OP_BR:    begin d_imm = imm_b; d_m1 = 1'b1; d_m2 = 1'b1; d_cmpop = funct3; end
      OP_LOAD: begin
        d_imm = imm_i; d_m2 = 1'b1; d_re = 1'b1; d_we = 1'b1;
        case (funct3)
          3'd0:    d_rd_m_sel = 4'd4;
          3'd1:    d_rd_m_sel = 4'd5;
          3'd2:    d_rd_m_sel = 4'd6;
          3'd4:    d_rd_m_sel = 4'd7;
          3'd5:    d_rd_m_sel = 4'd8;
          default: d_ill = 1'b1;
        endcase
      end
      OP_STORE: begin d_imm = imm_s; d_m2 = 1'b1; d_mwe = 1'b1; end
      OP_IMM, OP_REG: begin
        d_imm     = is_imm ? imm_i : '0;
        d_m2      = is_imm;
        d_cmp_sel = is_imm;
        d_we      = 1'b1;
        d_aluop   = funct3;
        case (funct3)
          3'b000: d_aluop = (!is_imm && head[30]) ? 3'b011 : 3'b000;
          3'b101: d_aluop = head[30] ? 3'b010 : 3'b101;
          3'b010: begin d_cmpop = 3'b100; d_rd_m_sel = 4'd1; end
          3'b011: begin d_cmpop = 3'b110; d_rd_m_sel = 4'd1; end
          default: ;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    if (head[11:7] == 5'd0) d_we = 1'b0;
  end

  // ---------------- load-use interlock ----------------
`ifdef ID_LOAD_USE_STALL_EN
  logic rs1_used, rs2_used;
  assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign rs2_used = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BR);
  assign hazard   = ex_valid && ex_mem_re && (ex_rd_s != 5'd0) &&
                    ((rs1_used && ex_rd_s == rs1_s) || (rs2_used && ex_rd_s == rs2_s));
`else
  logic unused_ex;
  assign unused_ex = ^{ex_valid, ex_mem_re, ex_rd_s};
  assign hazard    = 1'b0;
`endif

  // ---------------- output register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0; out_inst <= '0; out_pc <= '0; out_order <= '0;
      out_rd_s <= '0; out_rs1_v <= '0; out_rs2_v <= '0; out_imm <= '0;
      out_aluop <= '0; out_alu_m1_sel <= 1'b0; out_alu_m2_sel <= 1'b0;
      out_cmpop <= '0; out_cmp_sel <= 1'b0; out_rd_m_sel <= '0;
      out_regf_we <= 1'b0; out_mem_re <= 1'b0; out_mem_we <= 1'b0;
      out_funct3 <= '0; out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1; out_inst <= head; out_pc <= q_pc[rd_ptr];
      out_order <= q_order[rd_ptr]; out_rd_s <= head[11:7];
      out_rs1_v <= rs1_v; out_rs2_v <= rs2_v; out_imm <= d_imm;
      out_aluop <= d_aluop; out_alu_m1_sel <= d_m1; out_alu_m2_sel <= d_m2;
      out_cmpop <= d_cmpop; out_cmp_sel <= d_cmp_sel; out_rd_m_sel <= d_rd_m_sel;
      out_regf_we <= d_we; out_mem_re <= d_re; out_mem_we <= d_mwe;
      out_funct3 <= funct3; out_illegal <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_decode_queue.sv
// tb_id_decode_queue
//   Self-checking bench for id_decode_queue: directed scenarios followed by
//   randomized traffic, all checked cycle by cycle against a queue-based
//   reference model derived from the RV32I decode rules.
module tb_id_decode_queue;
  localparam int DEPTH   = 4;
  localparam int PC_W    = 32;
  localparam int ORDER_W = 64;
`ifdef ID_LOAD_USE_STALL_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, ex_valid, ex_mem_re, out_valid, out_ready;
  logic [31:0] in_inst, rs1_v, rs2_v, out_inst, out_rs1_v, out_rs2_v, out_imm;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [ORDER_W-1:0] in_order, out_order;
  logic [4:0] rs1_s, rs2_s, ex_rd_s, out_rd_s;
  logic [2:0] out_aluop, out_cmpop, out_funct3;
  logic out_alu_m1_sel, out_alu_m2_sel, out_cmp_sel, out_regf_we, out_mem_re, out_mem_we, out_illegal;
  logic [3:0] out_rd_m_sel;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  id_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .ORDER_W(ORDER_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_order(in_order),
    .rs1_s(rs1_s), .rs2_s(rs2_s), .rs1_v(rs1_v), .rs2_v(rs2_v),
    .ex_valid(ex_valid), .ex_mem_re(ex_mem_re), .ex_rd_s(ex_rd_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_order(out_order), .out_rd_s(out_rd_s), .out_rs1_v(out_rs1_v), .out_rs2_v(out_rs2_v),
    .out_imm(out_imm), .out_aluop(out_aluop), .out_alu_m1_sel(out_alu_m1_sel),
    .out_alu_m2_sel(out_alu_m2_sel), .out_cmpop(out_cmpop), .out_cmp_sel(out_cmp_sel),
    .out_rd_m_sel(out_rd_m_sel), .out_regf_we(out_regf_we), .out_mem_re(out_mem_re),
    .out_mem_we(out_mem_we), .out_funct3(out_funct3), .out_illegal(out_illegal)
  );

  // Register file stand-in: fixed distinct value per register.
  function automatic logic [31:0] regval(input logic [4:0] r);
    return 32'h9E3779B9 * (32'(r) + 32'd1);
  endfunction
  assign rs1_v = regval(rs1_s);
  assign rs2_v = regval(rs2_s);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] inst; logic [PC_W-1:0] pc; logic [ORDER_W-1:0] order;
  } ent_t;
  typedef struct packed { ent_t e; logic [31:0] r1; logic [31:0] r2; } slot_t;
  typedef struct packed {
    logic [31:0] imm; logic [2:0] aluop; logic m1; logic m2; logic [2:0] cmpop; logic cmp_sel;
    logic [3:0] rdm; logic we; logic re; logic mwe; logic ill;
    logic c_imm; logic c_aluop; logic c_msel; logic c_cmpop; logic c_cmpsel; logic c_rdm; logic c_ctl;
  } dec_t;

  ent_t  exp_q[$];
  logic  mov;
  slot_t mout;

  function automatic dec_t model_dec(input logic [31:0] w);
    dec_t d;
    logic [6:0] op;
    logic [2:0] f3;
    logic imm_form;
    int si, ss, sb, su, sj;
    int ld_sel [8];
    ld_sel = '{4, 5, 6, 0, 7, 8, 0, 0};
    op = w[6:0];
    f3 = w[14:12];
    // Immediates assembled by bit weight; sign comes from bit 31.
    si = int'($signed(w)) >>> 20;
    ss = (int'($signed(w)) >>> 25) * 32 + int'(w[11:7]);
    sb = (int'($signed(w)) >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    su = int'(w & 32'hFFFFF000);
    sj = (int'($signed(w)) >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    d = '0;
    d.c_imm = 1'b1;
    d.c_ctl = 1'b1;
    if (op == 7'h37) begin
      d.imm = su; d.rdm = 4'd2; d.c_rdm = 1'b1; d.we = 1'b1;
    end else if (op == 7'h17) begin
      d.imm = su; d.m1 = 1'b1; d.m2 = 1'b1; d.c_aluop = 1'b1; d.c_msel = 1'b1;
      d.rdm = 4'd0; d.c_rdm = 1'b1; d.we = 1'b1;
    end else if (op == 7'h6F) begin
      d.imm = sj; d.rdm = 4'd3; d.c_rdm = 1'b1; d.we = 1'b1;
    end else if (op == 7'h67) begin
      d.imm = si; d.rdm = 4'd3; d.c_rdm = 1'b1; d.we = 1'b1;
      d.m2 = 1'b1; d.c_aluop = 1'b1; d.c_msel = 1'b1;
    end else if (op == 7'h63) begin
      d.imm = sb; d.cmpop = f3; d.c_cmpop = 1'b1; d.c_cmpsel = 1'b1;
    end else if (op == 7'h03) begin
      d.imm = si; d.m2 = 1'b1; d.c_aluop = 1'b1; d.c_msel = 1'b1;
      d.re = 1'b1; d.we = 1'b1; d.rdm = 4'(ld_sel[f3]); d.c_rdm = 1'b1;
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
        d.ill = 1'b1; d.c_ctl = 1'b0; d.c_rdm = 1'b0;
      end
    end else if (op == 7'h23) begin
      d.imm = ss; d.m2 = 1'b1; d.c_aluop = 1'b1; d.c_msel = 1'b1; d.mwe = 1'b1;
    end else if (op == 7'h13 || op == 7'h33) begin
      imm_form = (op == 7'h13);
      d.imm = si; d.c_imm = imm_form;
      d.m2 = imm_form; d.c_msel = 1'b1;
      d.cmp_sel = imm_form; d.c_cmpsel = 1'b1;
      d.we = 1'b1; d.rdm = 4'd0; d.c_rdm = 1'b1;
      d.aluop = f3; d.c_aluop = 1'b1;
      if (f3 == 3'd0 && !imm_form && w[30]) d.aluop = 3'b011;
      if (f3 == 3'd5) d.aluop = w[30] ? 3'b010 : 3'b101;
      if (f3 == 3'd2 || f3 == 3'd3) begin
        d.c_aluop = 1'b0; d.rdm = 4'd1; d.c_cmpop = 1'b1;
        d.cmpop = (f3 == 3'd2) ? 3'b100 : 3'b110;
      end
    end else begin
      d.ill = 1'b1; d.c_imm = 1'b0;
    end
    if (w[11:7] == 5'd0) d.we = 1'b0;
    return d;
  endfunction

  function automatic logic model_hazard(input logic [31:0] w);
    logic [6:0] op;
    logic u1, u2;
    op = w[6:0];
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return HZ_EN && ex_valid && ex_mem_re && (ex_rd_s != 5'd0) &&
           ((u1 && ex_rd_s == w[19:15]) || (u2 && ex_rd_s == w[24:20]));
  endfunction

  task automatic model_step();
    logic iss, room;
    if (!rst) begin
      exp_q.delete(); mov = 1'b0; mout = '0;
    end else if (flush) begin
      exp_q.delete(); mov = 1'b0;
    end else begin
      room = (exp_q.size() < DEPTH);
      iss  = (exp_q.size() > 0) && !model_hazard(exp_q[0].inst) && (!mov || out_ready);
      if (iss) begin
        mout.e  = exp_q[0];
        mout.r1 = regval(exp_q[0].inst[19:15]);
        mout.r2 = regval(exp_q[0].inst[24:20]);
        void'(exp_q.pop_front());
        mov = 1'b1;
      end else if (mov && out_ready) begin
        mov = 1'b0;
      end
      if (in_valid && room) exp_q.push_back('{in_inst, in_pc, in_order});
    end
  endtask

  task automatic compare_outputs();
    dec_t d;
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(mov));
    if (exp_q.size() > 0) begin
      check("rs1_s", 64'(rs1_s), 64'(exp_q[0].inst[19:15]));
      check("rs2_s", 64'(rs2_s), 64'(exp_q[0].inst[24:20]));
    end
    if (mov) begin
      d = model_dec(mout.e.inst);
      check("out_inst", 64'(out_inst), 64'(mout.e.inst));
      check("out_pc", 64'(out_pc), 64'(mout.e.pc));
      check("out_order", 64'(out_order), 64'(mout.e.order));
      check("out_rd_s", 64'(out_rd_s), 64'(mout.e.inst[11:7]));
      check("out_rs1_v", 64'(out_rs1_v), 64'(mout.r1));
      check("out_rs2_v", 64'(out_rs2_v), 64'(mout.r2));
      check("out_funct3", 64'(out_funct3), 64'(mout.e.inst[14:12]));
      check("out_illegal", 64'(out_illegal), 64'(d.ill));
      if (d.c_imm)    check("out_imm", 64'(out_imm), 64'(d.imm));
      if (d.c_aluop)  check("out_aluop", 64'(out_aluop), 64'(d.aluop));
      if (d.c_msel)   check("out_alu_msel", 64'({out_alu_m1_sel, out_alu_m2_sel}), 64'({d.m1, d.m2}));
      if (d.c_cmpop)  check("out_cmpop", 64'(out_cmpop), 64'(d.cmpop));
      if (d.c_cmpsel) check("out_cmp_sel", 64'(out_cmp_sel), 64'(d.cmp_sel));
      if (d.c_rdm)    check("out_rd_m_sel", 64'(out_rd_m_sel), 64'(d.rdm));
      if (d.c_ctl)    check("out_ctl", 64'({out_regf_we, out_mem_re, out_mem_we}), 64'({d.we, d.re, d.mwe}));
    end
  endtask

  // ---------------- drivers ----------------
  logic [PC_W-1:0]    pc_ctr  = '0;
  logic [ORDER_W-1:0] ord_ctr = '0;

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic present(input logic [31:0] w);
    in_valid = 1'b1;
    in_inst  = w;
    in_pc    = pc_ctr;
    in_order = ord_ctr;
    pc_ctr   = pc_ctr + 4;
    ord_ctr  = ord_ctr + 1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11];
    logic [6:0] f7;
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F, 7'h0B};
    f7 = 7'($urandom);
    rd = 5'($urandom_range(0, 3));
    r1 = 5'($urandom_range(0, 3));
    r2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    f3 = 3'($urandom_range(0, 7));
    return {f7, r2, r1, f3, rd, ops[$urandom_range(0, 10)]};
  endfunction

  function automatic logic any_out_bits();
    return |{out_inst, out_pc, out_order, out_rd_s, out_rs1_v, out_rs2_v, out_imm, out_aluop,
             out_alu_m1_sel, out_alu_m2_sel, out_cmpop, out_cmp_sel, out_rd_m_sel,
             out_regf_we, out_mem_re, out_mem_we, out_funct3, out_illegal};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int hs;
    logic [ORDER_W-1:0] last_ord;
    logic [31:0] dec_list [5];
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_order = '0;
    ex_valid = 1'b0; ex_mem_re = 1'b0; ex_rd_s = '0; out_ready = 1'b0;
    mov = 1'b0; mout = '0;

    // Reset state
    repeat (2) step();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_fields", 64'(any_out_bits()), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b1;

    // addi x1,x0,5 through an empty pipe
    out_ready = 1'b1;
    present(32'h00500093);
    step();
    in_valid = 1'b0;
    check("lat_e0_valid", 64'(out_valid), 64'(0));
    step();
    check("lat_e1_valid", 64'(out_valid), 64'(1));
    check("addi_imm", 64'(out_imm), 64'(5));
    check("addi_aluop", 64'(out_aluop), 64'(0));
    check("addi_m2", 64'(out_alu_m2_sel), 64'(1));
    check("addi_we", 64'(out_regf_we), 64'(1));
    check("addi_rd", 64'(out_rd_s), 64'(1));
    step();

    // Fill with EX stalled, then drain in order
    out_ready = 1'b0;
    repeat (7) begin present(rand_inst()); step(); end
    in_valid = 1'b0;
    check("full_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    hs = 0;
    last_ord = '0;
    repeat (8) begin
      if (out_valid) begin
        if (hs > 0) check("drain_order_inc", 64'(out_order > last_ord), 64'(1));
        last_ord = out_order;
        hs++;
      end
      step();
    end
    check("drain_count", 64'(hs), 64'(DEPTH + 1));

    // Load-use hazard on add x2,x1,x3
    ex_valid = 1'b1; ex_mem_re = 1'b1; ex_rd_s = 5'd1;
    present(32'h00308133);
    step();
    in_valid = 1'b0;
    step();
`ifdef ID_LOAD_USE_STALL_EN
    check("hz_stall_a", 64'(out_valid), 64'(0));
    step();
    check("hz_stall_b", 64'(out_valid), 64'(0));
    ex_valid = 1'b0;
    step();
    check("hz_release", 64'(out_valid), 64'(1));
`else
    check("hz_nostall", 64'(out_valid), 64'(1));
    ex_valid = 1'b0;
`endif
    ex_mem_re = 1'b0; ex_rd_s = '0;
    repeat (2) step();

    // Flush with a full queue and a valid output
    out_ready = 1'b0;
    repeat (6) begin present(rand_inst()); step(); end
    check("pre_flush_valid", 64'(out_valid), 64'(1));
    flush = 1'b1;
    present(32'h07700493);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    repeat (3) begin step(); check("flush_no_leak", 64'(out_valid), 64'(0)); end

    // Decode corner cases, back to back
    dec_list = '{32'h407302B3, 32'h4022D293, 32'h00014203, 32'h000000FF, 32'h00100013};
    for (int i = 0; i < 6; i++) begin
      if (i < 5) present(dec_list[i]);
      else in_valid = 1'b0;
      step();
      if (i >= 1) begin
        check("dec_stream_valid", 64'(out_valid), 64'(1));
        case (i - 1)
          0: check("sub_aluop", 64'(out_aluop), 64'(3'b011));
          1: begin
            check("srai_aluop", 64'(out_aluop), 64'(3'b010));
            check("srai_m2", 64'(out_alu_m2_sel), 64'(1));
          end
          2: begin
            check("lbu_rd_m_sel", 64'(out_rd_m_sel), 64'(7));
            check("lbu_mem_re", 64'(out_mem_re), 64'(1));
          end
          3: begin
            check("op7f_illegal", 64'(out_illegal), 64'(1));
            check("op7f_we", 64'(out_regf_we), 64'(0));
          end
          default: check("addi_x0_we", 64'(out_regf_we), 64'(0));
        endcase
      end
    end
    step();

    // Reset mid-operation
    out_ready = 1'b0;
    repeat (3) begin present(rand_inst()); step(); end
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    rst = 1'b0;
    present(rand_inst());
    step();
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_fields", 64'(any_out_bits()), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b1; in_valid = 1'b0;
    step();

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 9) < 7) present(rand_inst());
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      ex_valid  = 1'($urandom_range(0, 1));
      ex_mem_re = 1'($urandom_range(0, 1));
      ex_rd_s   = 5'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 127) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
